// File: rtl/cint_controller_n_pkg.sv
// cint_controller_n_pkg: shared FSM encoding, default vector base and priority encoder
package cint_controller_n_pkg;
  typedef enum logic [1:0] {IDLE, PEND, VECTOR, SERVICE} state_e;
  localparam int VEC_BASE_DEF = 12;
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest_idx = 4'(i);
  endfunction
endpackage

// File: rtl/cint_controller_n_if.sv
// cint_controller_n_if: core/decoder-chain signals of the interrupt controller
interface cint_controller_n_if #(parameter int N_CH = 4, parameter int VEC_W = 4);
  localparam int ID_W = $clog2(N_CH);
  logic             not_decodingIn;
  logic [N_CH-1:0]  not_cint;
  logic [N_CH-1:0]  cint_mask;
  logic             not_isXPT;
  logic             cint_ack;
  logic             cint_done;
  logic             enable_cint;
  logic [VEC_W-1:0] PA_Select_IOP;
  logic [ID_W-1:0]  cint_id;
  logic             busy;
  logic             not_decodingOut;
  modport slave (
    input  not_decodingIn, not_cint, cint_mask, not_isXPT, cint_ack, cint_done,
    output enable_cint, PA_Select_IOP, cint_id, busy, not_decodingOut
  );
  modport master (
    output not_decodingIn, not_cint, cint_mask, not_isXPT, cint_ack, cint_done,
    input  enable_cint, PA_Select_IOP, cint_id, busy, not_decodingOut
  );
endinterface

// File: rtl/cint_controller_n_pending.sv
// cint_controller_n_pending: per-channel falling-edge capture and pending register
module cint_controller_n_pending #(
  parameter int N_CH = 4,
  parameter int EDGE_MODE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] not_cint,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] pending
);
  logic [N_CH-1:0] prev_q, prev_d, pend_q, pend_d;
  // a new edge outranks the clear of the channel just vectored
  always_comb begin
    prev_d = not_cint;
    pend_d = (pend_q & ~clr) | (~not_cint & prev_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '1;
      pend_q <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end
  assign pending = (EDGE_MODE != 0) ? pend_q : ~not_cint;
endmodule

// File: rtl/cint_controller_n.sv
// cint_controller_n: N-channel CINT controller; lowest unmasked channel claims the chain
module cint_controller_n import cint_controller_n_pkg::*; #(
  parameter int N_CH = 4,
  parameter int VEC_W = 4,
  parameter int VEC_BASE = VEC_BASE_DEF,
  parameter int EDGE_MODE = 1
) (
  input logic clk,
  input logic reset,
  cint_controller_n_if.slave bus
);
  localparam int ID_W = $clog2(N_CH);
  state_e state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [N_CH-1:0] pending, req, clr;
  cint_controller_n_pending #(.N_CH(N_CH), .EDGE_MODE(EDGE_MODE)) u_pend (
    .clk(clk), .reset(reset), .not_cint(bus.not_cint), .clr(clr), .pending(pending)
  );
  assign req = pending & ~bus.cint_mask;
  assign clr = (state_q == VECTOR && bus.cint_ack) ? N_CH'(1) << id_q : '0;
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    case (state_q)
      IDLE: if (|req && !bus.not_decodingIn) begin
        state_d = PEND;
        id_d = ID_W'(lowest_idx(16'(req)));
      end
      PEND: state_d = bus.not_decodingIn ? IDLE : (!bus.not_isXPT ? VECTOR : PEND);
      VECTOR: state_d = bus.cint_ack ? SERVICE : VECTOR;
      SERVICE: state_d = bus.cint_done ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
    end
  end
  assign bus.enable_cint = state_q == VECTOR;
  assign bus.PA_Select_IOP = (state_q == VECTOR) ? VEC_W'(VEC_BASE) + VEC_W'(id_q) : '0;
  assign bus.cint_id = id_q;
  assign bus.busy = state_q != IDLE;
  assign bus.not_decodingOut = bus.not_decodingIn | state_q == PEND | state_q == VECTOR;
endmodule
